// File: rtl/spike_pkg.sv
// Shared types and helpers for the spiking-network class readout.
package spike_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } dec_state_t;

    // One step of a signed counter of 'width' bits that saturates at both rails.
    // pos alone counts up, neg alone counts down, both or neither hold.
    function automatic int sat_step(input int cur, input logic up, input logic dn,
                                    input int unsigned width);
        int hi;
        int lo;
        int nxt;
        hi  = (1 <<< (width - 1)) - 1;
        lo  = -(1 <<< (width - 1));
        nxt = cur;
        if (up && !dn && cur < hi) begin
            nxt = cur + 1;
        end else if (dn && !up && cur > lo) begin
            nxt = cur - 1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/spike_net_counter.sv
// Signed saturating up/down counter for one output-neuron spike pair.
module spike_net_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    pos,
    input  logic                    neg,
    input  logic                    enable,
    output logic signed [WIDTH-1:0] count
);
    import spike_pkg::*;

    int next_count;

    // Next value with saturation applied.
    always_comb begin
        next_count = sat_step(int'(count), pos, neg, WIDTH);
    end

    // Clear has priority over counting; counting only while enabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= WIDTH'(next_count);
        end
    end

endmodule

// File: rtl/spike_class_decoder.sv
// Integrates per-class spike trains over a fixed window, then picks the
// winning class with a sequential argmax and reports it via busy/done.
module spike_class_decoder #(
    parameter  int unsigned CLASS_COUNT = 10,
    parameter  int unsigned WINDOW      = 64,
    parameter  int unsigned COUNT_WIDTH = 8,
    localparam int unsigned IDX_WIDTH   = $clog2(CLASS_COUNT)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [CLASS_COUNT-1:0] pos_spike,
    input  logic [CLASS_COUNT-1:0] neg_spike,
    output logic                   busy,
    output logic                   done,
    output logic [IDX_WIDTH-1:0]   class_idx,
    output logic [COUNT_WIDTH-1:0] class_score
);
    import spike_pkg::*;

    localparam int unsigned WIN_W = $clog2(WINDOW) + 1;

    dec_state_t                    state;
    logic                          start_q;
    logic                          accept;
    logic [WIN_W-1:0]              win_cnt;
    logic [IDX_WIDTH-1:0]          scan_idx;
    logic [IDX_WIDTH-1:0]          best_idx;
    logic signed [COUNT_WIDTH-1:0] best_score;
    logic signed [COUNT_WIDTH-1:0] scan_val;
    logic                          take;
    logic [IDX_WIDTH-1:0]          cand_idx;
    logic signed [COUNT_WIDTH-1:0] cand_score;
    logic signed [COUNT_WIDTH-1:0] counts [CLASS_COUNT];

    // start is registered first: the request sampled at one edge is accepted
    // (counters cleared, ACCUM entered) at the following edge.
    assign accept = (state == IDLE) && start_q;
    assign busy   = (state == ACCUM) || (state == SCAN);
    assign done   = (state == DONE);

    genvar gi;
    generate
        for (gi = 0; gi < CLASS_COUNT; gi++) begin : gen_cnt
            spike_net_counter #(
                .WIDTH(COUNT_WIDTH)
            ) u_cnt (
                .clk   (clk),
                .reset (reset),
                .clear (accept),
                .pos   (pos_spike[gi]),
                .neg   (neg_spike[gi]),
                .enable(state == ACCUM),
                .count (counts[gi])
            );
        end
    endgenerate

    // Argmax step: class 0 seeds the best, later classes win only if strictly greater.
    always_comb begin
        scan_val   = counts[scan_idx];
        take       = (scan_idx == '0) || (scan_val > best_score);
        cand_idx   = take ? scan_idx : best_idx;
        cand_score = take ? scan_val : best_score;
    end

    // Request capture: only a start seen while idle and not already pending counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_q <= 1'b0;
        end else begin
            start_q <= start && (state == IDLE) && !start_q;
        end
    end

    // Control FSM with window counter, scan pointer and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            win_cnt     <= '0;
            scan_idx    <= '0;
            best_idx    <= '0;
            best_score  <= '0;
            class_idx   <= '0;
            class_score <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        win_cnt <= '0;
                        state   <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (win_cnt == WIN_W'(WINDOW - 1)) begin
                        scan_idx <= '0;
                        state    <= SCAN;
                    end else begin
                        win_cnt <= win_cnt + WIN_W'(1);
                    end
                end
                SCAN: begin
                    best_idx   <= cand_idx;
                    best_score <= cand_score;
                    if (scan_idx == IDX_WIDTH'(CLASS_COUNT - 1)) begin
                        class_idx   <= cand_idx;
                        class_score <= cand_score;
                        state       <= DONE;
                    end else begin
                        scan_idx <= scan_idx + IDX_WIDTH'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_class_decoder.sv
// Self-checking bench: a timeline model of the decoder checked every cycle
// against two instances (6-bit and 4-bit counters) plus literal expectations.
module tb_spike_class_decoder;

    localparam int NC  = 4;
    localparam int WIN = 16;
    localparam int T_DONE = WIN + NC + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [NC-1:0] pos_spike = '0;
    logic [NC-1:0] neg_spike = '0;

    logic          busy,  done;
    logic [1:0]    class_idx;
    logic [5:0]    class_score;
    logic          busy2, done2;
    logic [1:0]    class_idx2;
    logic [3:0]    class_score2;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    spike_class_decoder #(
        .CLASS_COUNT(NC), .WINDOW(WIN), .COUNT_WIDTH(6)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .pos_spike(pos_spike), .neg_spike(neg_spike),
        .busy(busy), .done(done), .class_idx(class_idx), .class_score(class_score)
    );

    spike_class_decoder #(
        .CLASS_COUNT(NC), .WINDOW(WIN), .COUNT_WIDTH(4)
    ) dut2 (
        .clk(clk), .reset(reset), .start(start),
        .pos_spike(pos_spike), .neg_spike(neg_spike),
        .busy(busy2), .done(done2), .class_idx(class_idx2), .class_score(class_score2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_t = edges since start was sampled in idle (-1 when idle).
    int m_t = -1;
    int m_c6 [NC];
    int m_c4 [NC];
    int m_idx6 = 0, m_score6 = 0, m_idx4 = 0, m_score4 = 0;

    function automatic int clamp_add(input int c, input bit p, input bit n, input int w);
        int v;
        v = c + ((p && !n) ? 1 : 0) - ((n && !p) ? 1 : 0);
        if (v > (1 << (w - 1)) - 1) v = (1 << (w - 1)) - 1;
        if (v < -(1 << (w - 1)))    v = -(1 << (w - 1));
        return v;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_t = -1;
                for (int i = 0; i < NC; i++) begin m_c6[i] = 0; m_c4[i] = 0; end
                m_idx6 = 0; m_score6 = 0; m_idx4 = 0; m_score4 = 0;
            end else if (m_t < 0) begin
                if (start) m_t = 0;
            end else begin
                m_t++;
                if (m_t == 1) begin
                    for (int i = 0; i < NC; i++) begin m_c6[i] = 0; m_c4[i] = 0; end
                end else if (m_t >= 2 && m_t <= WIN + 1) begin
                    for (int i = 0; i < NC; i++) begin
                        m_c6[i] = clamp_add(m_c6[i], pos_spike[i], neg_spike[i], 6);
                        m_c4[i] = clamp_add(m_c4[i], pos_spike[i], neg_spike[i], 4);
                    end
                end else if (m_t == T_DONE) begin
                    m_idx6 = 0; m_idx4 = 0;
                    for (int i = 1; i < NC; i++) begin
                        if (m_c6[i] > m_c6[m_idx6]) m_idx6 = i;
                        if (m_c4[i] > m_c4[m_idx4]) m_idx4 = i;
                    end
                    m_score6 = m_c6[m_idx6];
                    m_score4 = m_c4[m_idx4];
                end else if (m_t == T_DONE + 1) begin
                    m_t = -1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("busy",   int'(busy),  int'(m_t >= 1 && m_t <= T_DONE - 1));
                chk("done",   int'(done),  int'(m_t == T_DONE));
                chk("idx",    int'(class_idx), m_idx6);
                chk("score",  int'($signed(class_score)), m_score6);
                chk("busy2",  int'(busy2), int'(m_t >= 1 && m_t <= T_DONE - 1));
                chk("done2",  int'(done2), int'(m_t == T_DONE));
                chk("idx2",   int'(class_idx2), m_idx4);
                chk("score2", int'($signed(class_score2)), m_score4);
                for (int i = 0; i < NC; i++) begin
                    chk("cnt6", int'(dut.counts[i]),  m_c6[i]);
                    chk("cnt4", int'(dut2.counts[i]), m_c4[i]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [NC-1:0] acc_pos [WIN];
    logic [NC-1:0] acc_neg [WIN];
    logic [NC-1:0] out_pos;
    int mid_start;
    int done_at, busy_cnt, done_cnt;

    task automatic clear_pat();
        for (int k = 0; k < WIN; k++) begin acc_pos[k] = '0; acc_neg[k] = '0; end
        out_pos = '0;
        mid_start = -1;
    endtask

    // Pulse start, feed the window pattern, observe for a bounded 40 cycles.
    task automatic classify();
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        @(negedge clk);
        start = 1'b1; pos_spike = out_pos; neg_spike = '0;
        for (int nn = 1; nn <= 40; nn++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; done_at = nn - 1; end
            start = 1'b0;
            if (nn >= 2 && nn <= WIN + 1) begin
                pos_spike = acc_pos[nn-2];
                neg_spike = acc_neg[nn-2];
                start     = (nn - 2 == mid_start);
            end else begin
                pos_spike = out_pos;
                neg_spike = '0;
            end
        end
        pos_spike = '0;
    endtask

    initial begin
        #2 reset = 1'b0;
        #20 reset = 1'b1;
        cmp_en = 1'b1;
        chk("reset_busy",  int'(busy), 0);
        chk("reset_idx",   int'(class_idx), 0);
        chk("reset_score", int'(class_score), 0);

        // single-class winner
        clear_pat();
        for (int k = 0; k < WIN; k++) acc_pos[k] = 4'b0100;
        classify();
        chk("t1_idx", int'(class_idx), 2);
        chk("t1_score", int'($signed(class_score)), 16);
        chk("t1_done_edge", done_at, 21);
        chk("t1_done_count", done_cnt, 1);
        chk("t1_busy_cycles", busy_cnt, 20);
        chk("t1_score_w4", int'($signed(class_score2)), 7);

        // reset mid-ACCUM, then a fresh window
        @(negedge clk); start = 1'b1; pos_spike = 4'b0010;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_busy",  int'(busy), 0);
        chk("rst_done",  int'(done), 0);
        chk("rst_idx",   int'(class_idx), 0);
        chk("rst_score", int'(class_score), 0);
        pos_spike = '0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        clear_pat();
        for (int k = 0; k < 3; k++) acc_pos[k] = 4'b1000;
        classify();
        chk("rf_idx", int'(class_idx), 3);
        chk("rf_score", int'($signed(class_score)), 3);
        chk("rf_done_edge", done_at, 21);

        // tie and negative
        clear_pat();
        for (int k = 0; k < 5; k++) acc_pos[k] = 4'b1010;
        for (int k = 0; k < 7; k++) acc_neg[k] = 4'b0001;
        classify();
        chk("tie_idx", int'(class_idx), 1);
        chk("tie_score", int'($signed(class_score)), 5);
        chk("tie_cnt0", int'(dut.counts[0]), -7);

        // cancellation
        clear_pat();
        for (int k = 0; k < WIN; k++) begin acc_pos[k] = 4'b0001; acc_neg[k] = 4'b0001; end
        classify();
        chk("canc_idx", int'(class_idx), 0);
        chk("canc_score", int'($signed(class_score)), 0);

        // saturation
        clear_pat();
        for (int k = 0; k < WIN; k++) begin acc_pos[k] = 4'b0001; acc_neg[k] = 4'b0010; end
        classify();
        chk("sat_idx_w4", int'(class_idx2), 0);
        chk("sat_score_w4", int'($signed(class_score2)), 7);
        chk("sat_cnt1_w4", int'(dut2.counts[1]), -8);
        chk("sat_score_w6", int'($signed(class_score)), 16);
        chk("sat_cnt1_w6", int'(dut.counts[1]), -16);

        // gating: spikes outside ACCUM plus a stray start mid-window
        clear_pat();
        out_pos = 4'b1000;
        mid_start = 8;
        classify();
        chk("gate_idx", int'(class_idx), 0);
        chk("gate_score", int'($signed(class_score)), 0);
        chk("gate_done_count", done_cnt, 1);
        chk("gate_done_edge", done_at, 21);
        chk("gate_busy_cycles", busy_cnt, 20);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spike_class_decoder.md
Name: spike_class_decoder

Overview:
Readout stage at the output end of the spiking network. Takes the positive/negative spike trains emitted by the output-layer spiking neurons (one pair per digit class) and integrates them over a fixed observation window into per-class signed net spike counts. It then selects the winning class by a sequential argmax and reports it through a start/busy/done handshake to the display/top-level logic.

Parameters:
CLASS_COUNT, 10, number of output neurons/classes
WINDOW, 64, number of clock cycles over which spikes are integrated (>=1)
COUNT_WIDTH, 8, width of each signed per-class net counter and of class_score
IDX_WIDTH, $clog2(CLASS_COUNT), width of class_idx (derived, not overridden)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request a new classification; accepted only in IDLE
pos_spike  input  CLASS_COUNT  positive spike per class, bit i = class i
neg_spike  input  CLASS_COUNT  negative spike per class, bit i = class i
busy  output  1  high from the cycle after start is accepted until done is pulsed
done  output  1  one-cycle pulse, result valid
class_idx  output  IDX_WIDTH  winning class, held until next accepted start
class_score  output  COUNT_WIDTH  signed net count of winning class, held likewise

Behaviour:
- Reset (async, reset=0): state IDLE, all counters 0, busy=0, done=0, class_idx=0, class_score=0. Applies immediately mid-operation and discards any partial window.
- FSM states: IDLE, ACCUM, SCAN, DONE.
- IDLE: busy=0. start=1 clears all counters and the window counter, then moves to ACCUM. class_idx and class_score keep their last values until SCAN completes.
- ACCUM: busy=1. Exactly WINDOW cycles are sampled, starting the cycle after start is accepted. Per class each cycle:
  - pos only: +1
  - neg only: -1
  - both or neither: unchanged
- Counter arithmetic: signed COUNT_WIDTH, saturating at +(2^(COUNT_WIDTH-1)-1) and -2^(COUNT_WIDTH-1). The counter never wraps.
- Transition from ACCUM to SCAN after the WINDOW-th sample.
- SCAN: busy=1. Examines one class per cycle, index 0 up to CLASS_COUNT-1, so it lasts CLASS_COUNT cycles.
  - The running best is initialised from class 0.
  - A later class replaces the best only if its count is strictly greater. Ties therefore resolve to the lowest index.
- DONE: busy=0, done=1 for exactly one cycle. class_idx/class_score are updated on entry to DONE. The FSM returns to IDLE on the next cycle.
- Latency: start sampled high at edge 0 gives done high in the cycle after edge WINDOW+CLASS_COUNT+1.
- start while busy or in DONE: ignored, with no effect on the current window.
- Spikes presented in IDLE, SCAN or DONE are not counted.
- A start held high continuously re-triggers one cycle after each done (back-to-back classifications).

Decomposition:
- Shared package spike_pkg holds:
  - the decoder state enum typedef (IDLE/ACCUM/SCAN/DONE)
  - a saturating signed step function parameterised by width
- One natural sub-module: spike_net_counter, a single signed saturating up/down counter with clear, pos, neg and enable inputs. It is instantiated CLASS_COUNT times via generate.
- Window counter, argmax scan and FSM live in spike_class_decoder.

Test Plan:
The bench uses CLASS_COUNT=4, WINDOW=16, COUNT_WIDTH=6 (range -32..31) unless stated.
- Winner, single class: pos_spike=4'b0100 for all 16 ACCUM cycles. Expect class_idx=2, class_score=16, done exactly one cycle at start+21, busy high for the 20 cycles before it.
- Tie and negative: classes 1 and 3 each get 5 pos spikes; class 0 gets 7 neg spikes. Expect class_idx=1, class_score=5.
- Cancellation: pos and neg both asserted on class 0 every cycle, no other spikes. Expect all counts 0, class_idx=0, class_score=0.
- Saturation (COUNT_WIDTH=4): class 0 gets pos every cycle and class 1 gets neg every cycle. Expect class_idx=0, class_score=7, and class 1 internal count -8 with no wrap.
- Gating: spikes on class 3 only during IDLE and SCAN, plus a second start pulse mid-ACCUM. Expect class_idx=0, score=0, a single done, and window timing unchanged.
- Reset mid-ACCUM: reset low for 2 cycles at ACCUM cycle 8. Expect busy=0, done=0, class_idx=0 and class_score=0 immediately (asynchronous). A new start then yields a result from the fresh window only.
